// File: rtl/reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_sched
// Description : Write-port scheduler for the register bank. Two writeback
//               requesters (port A = ALU result, port B = LDR load data) each
//               hand requests over valid/ready into a one-entry holding
//               buffer. Buffered writes are serialised onto the bank's single
//               write port as a registered one-hot enable plus write data.
//               A pending bitmap is published for upstream hazard logic.
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               a_valid/a_ready/a_dest/a_data - ALU writeback handshake
//               b_valid/b_ready/b_dest/b_data - LDR writeback handshake
//               enable                    - one-hot bank write enable (registered)
//               ldr_data                  - bank write data (registered)
//               pending                   - per-register outstanding-write bitmap
//               idle                      - no buffered or in-flight write
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_W-1:0]    a_dest,
    input  logic [DATA_W-1:0]    a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_W-1:0]    b_dest,
    input  logic [DATA_W-1:0]    b_data,
    output logic [2**ADDR_W-1:0] enable,
    output logic [DATA_W-1:0]    ldr_data,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 idle
);

    localparam int               c_NREG  = 2**ADDR_W;
    localparam logic [c_NREG-1:0] c_ONE  = {{(c_NREG-1){1'b0}}, 1'b1};

    // Per-port buffer states
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]        r_a_state;
    logic [0:0]        r_b_state;
    logic [ADDR_W-1:0] r_a_dest;
    logic [ADDR_W-1:0] r_b_dest;
    logic [DATA_W-1:0] r_a_data;
    logic [DATA_W-1:0] r_b_data;
    logic              r_age;   // 0: A holds the older entry, 1: B does
    logic              r_tie;   // both entries were captured at the same edge
    logic              r_rr;    // tie-break pointer, 0: A first, 1: B first
    logic [c_NREG-1:0] r_enable;
    logic [DATA_W-1:0] r_ldr_data;

    logic [0:0]        w_a_state_nxt;
    logic [0:0]        w_b_state_nxt;
    logic              w_age_nxt;
    logic              w_tie_nxt;
    logic              w_rr_nxt;

    logic              w_a_full;
    logic              w_b_full;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_gnt_any;
    logic              w_a_load;
    logic              w_b_load;
    logic [ADDR_W-1:0] w_gnt_dest;
    logic [DATA_W-1:0] w_gnt_data;

    assign w_a_full = (r_a_state == c_FULL);
    assign w_b_full = (r_b_state == c_FULL);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_state  <= c_EMPTY;
            r_b_state  <= c_EMPTY;
            r_a_dest   <= '0;
            r_b_dest   <= '0;
            r_a_data   <= '0;
            r_b_data   <= '0;
            r_age      <= 1'b0;
            r_tie      <= 1'b0;
            r_rr       <= 1'b0;
            r_enable   <= '0;
            r_ldr_data <= '0;
        end else begin
            r_a_state <= w_a_state_nxt;
            r_b_state <= w_b_state_nxt;
            r_age     <= w_age_nxt;
            r_tie     <= w_tie_nxt;
            r_rr      <= w_rr_nxt;
            if (w_a_load) begin
                r_a_dest <= a_dest;
                r_a_data <= a_data;
            end
            if (w_b_load) begin
                r_b_dest <= b_dest;
                r_b_data <= b_data;
            end
            r_enable <= w_gnt_any ? (c_ONE << w_gnt_dest) : '0;
            if (w_gnt_any) begin
                r_ldr_data <= w_gnt_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_a_load      = a_valid & a_ready;
        w_b_load      = b_valid & b_ready;
        w_a_state_nxt = r_a_state;
        w_b_state_nxt = r_b_state;
        w_age_nxt     = r_age;
        w_tie_nxt     = r_tie;
        w_rr_nxt      = r_rr;

        case (r_a_state)
            c_EMPTY: if (w_a_load) w_a_state_nxt = c_FULL;
            default: if (w_gnt_a && !w_a_load) w_a_state_nxt = c_EMPTY;
        endcase

        case (r_b_state)
            c_EMPTY: if (w_b_load) w_b_state_nxt = c_FULL;
            default: if (w_gnt_b && !w_b_load) w_b_state_nxt = c_EMPTY;
        endcase

        // A freshly loaded entry is always the younger one; a reload while
        // granted counts as fresh content.
        if (w_a_state_nxt == c_FULL && w_b_state_nxt == c_FULL) begin
            if (w_a_load && w_b_load) begin
                w_tie_nxt = 1'b1;
            end else if (w_a_load) begin
                w_age_nxt = 1'b1;
                w_tie_nxt = 1'b0;
            end else if (w_b_load) begin
                w_age_nxt = 1'b0;
                w_tie_nxt = 1'b0;
            end
        end else begin
            w_tie_nxt = 1'b0;
        end

        // Pointer only advances when it actually decided a grant.
        if (w_a_full && w_b_full && r_tie) begin
            w_rr_nxt = ~r_rr;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: grant depends on state only, so ready never sees valid.
    // ------------------------------------------------------------------------
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (w_a_full && w_b_full) begin
            if (r_tie) begin
                w_gnt_a = ~r_rr;
                w_gnt_b =  r_rr;
            end else begin
                w_gnt_a = ~r_age;
                w_gnt_b =  r_age;
            end
        end else if (w_a_full) begin
            w_gnt_a = 1'b1;
        end else if (w_b_full) begin
            w_gnt_b = 1'b1;
        end

        w_gnt_any  = w_gnt_a | w_gnt_b;
        w_gnt_dest = w_gnt_b ? r_b_dest : r_a_dest;
        w_gnt_data = w_gnt_b ? r_b_data : r_a_data;

        a_ready = ~w_a_full | w_gnt_a;
        b_ready = ~w_b_full | w_gnt_b;
    end

    // ------------------------------------------------------------------------
    // Pending bitmap: buffered destinations plus the write on the output stage
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_NREG; gi++) begin : g_pending
            assign pending[gi] = (w_a_full && (r_a_dest == ADDR_W'(gi)))
                               | (w_b_full && (r_b_dest == ADDR_W'(gi)))
                               | r_enable[gi];
        end
    endgenerate

    assign enable   = r_enable;
    assign ldr_data = r_ldr_data;
    assign idle     = ~w_a_full & ~w_b_full & (r_enable == '0);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_sched
// Description : Directed self-checking bench for reg_write_sched, with a
//               behavioural register bank driven by the DUT write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_sched;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [3:0]  a_dest, b_dest;
    logic [31:0] a_data, b_data;
    logic [15:0] enable;
    logic [31:0] ldr_data;
    logic [15:0] pending;
    logic        idle;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] bank     [16];
    logic [31:0] exp_bank [16];

    reg_write_sched #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
        .enable(enable), .ldr_data(ldr_data), .pending(pending), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register bank
    always @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (enable[i]) bank[i] <= ldr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int          a_idx, b_idx, np, first_c, last_c, writes, viol, n_acc, n_pulse;
    logic        acc_a, acc_b;
    logic [15:0] p_en   [32];
    logic [31:0] p_data [32];

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = '0;
        rst = 1'b1;
        a_valid = 0; a_dest = 0; a_data = 0;
        b_valid = 0; b_dest = 0; b_data = 0;

        // ---------------- reset state ----------------
        step(); step();
        check("rst_enable",  32'(enable),  32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_idle",    32'(idle),    32'h1);
        check("rst_a_ready", 32'(a_ready), 32'h1);
        check("rst_b_ready", 32'(b_ready), 32'h1);
        rst = 1'b0;
        step();

        // ---------------- single write ----------------
        a_valid = 1; a_dest = 4'd3; a_data = 32'hDEADBEEF;
        step();                               // accept edge
        a_valid = 0;
        check("single_pend_acc", 32'(pending), 32'h0008);
        check("single_en_acc",   32'(enable),  32'h0);
        check("single_idle_acc", 32'(idle),    32'h0);
        step();                               // enable edge
        check("single_en",    32'(enable),  32'h0008);
        check("single_data",  ldr_data,     32'hDEADBEEF);
        check("single_pend",  32'(pending), 32'h0008);
        step();                               // bank capture edge
        check("single_en_off", 32'(enable),  32'h0);
        check("single_pend0",  32'(pending), 32'h0);
        check("single_r3",     bank[3],      32'hDEADBEEF);
        check("single_idle",   32'(idle),    32'h1);

        // ---------------- simultaneous fill, pointer at A ----------------
        a_valid = 1; a_dest = 4'd1; a_data = 32'd11;
        b_valid = 1; b_dest = 4'd2; b_data = 32'd22;
        step();
        a_valid = 0; b_valid = 0;
        check("sim1_pend", 32'(pending), 32'h0006);
        step();
        check("sim1_en0",   32'(enable), 32'h0002);
        check("sim1_dat0",  ldr_data,    32'd11);
        step();
        check("sim1_en1",   32'(enable), 32'h0004);
        check("sim1_dat1",  ldr_data,    32'd22);
        step();
        check("sim1_idle",  32'(idle),   32'h1);

        // ---------------- repeat: pointer now at B ----------------
        a_valid = 1; b_valid = 1;
        step();
        a_valid = 0; b_valid = 0;
        step();
        check("sim2_en0",   32'(enable), 32'h0004);
        check("sim2_dat0",  ldr_data,    32'd22);
        step();
        check("sim2_en1",   32'(enable), 32'h0002);
        check("sim2_dat1",  ldr_data,    32'd11);
        step();

        // ---------------- ordering on a shared destination ----------------
        b_valid = 1; b_dest = 4'd5; b_data = 32'd7;
        step();
        b_valid = 0;
        a_valid = 1; a_dest = 4'd5; a_data = 32'd9;
        step();
        a_valid = 0;
        check("order_en0",   32'(enable),  32'h0020);
        check("order_dat0",  ldr_data,     32'd7);
        check("order_pend0", 32'(pending), 32'h0020);
        step();
        check("order_en1",   32'(enable),  32'h0020);
        check("order_dat1",  ldr_data,     32'd9);
        check("order_pend1", 32'(pending), 32'h0020);
        step();
        check("order_pend2", 32'(pending), 32'h0);
        check("order_r5",    bank[5],      32'd9);

        // ---------------- backpressure streaming ----------------
        a_idx = 0; b_idx = 0; np = 0; first_c = -1; last_c = -1;
        a_valid = 1; a_dest = 4'd0; a_data = 32'hA000;
        b_valid = 1; b_dest = 4'd8; b_data = 32'hB000;
        for (int c = 0; c < 40; c++) begin
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            step();
            if (enable != 16'h0) begin
                if (np < 32) begin
                    p_en[np]   = enable;
                    p_data[np] = ldr_data;
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                np++;
            end
            if (acc_a) a_idx++;
            if (acc_b) b_idx++;
            a_valid = (a_idx < 8); a_dest = 4'(a_idx);     a_data = 32'hA000 + 32'(a_idx);
            b_valid = (b_idx < 8); b_dest = 4'(8 + b_idx); b_data = 32'hB000 + 32'(b_idx);
        end
        check("bp_pulses", 32'(np),               32'd16);
        check("bp_span",   32'(last_c - first_c), 32'd15);
        for (int k = 0; k < 16 && k < np; k++) begin
            if (k % 2 == 0) begin
                check($sformatf("bp_en%0d", k),  32'(p_en[k]), 32'h1 << (k / 2));
                check($sformatf("bp_dat%0d", k), p_data[k],    32'hA000 + 32'(k / 2));
            end else begin
                check($sformatf("bp_en%0d", k),  32'(p_en[k]), 32'h1 << (8 + k / 2));
                check($sformatf("bp_dat%0d", k), p_data[k],    32'hB000 + 32'(k / 2));
            end
        end
        check("bp_idle", 32'(idle), 32'h1);

        // ---------------- reset mid-operation ----------------
        // Pointer sits at B after the single tie in the stream above.
        a_valid = 1; a_dest = 4'd6; a_data = 32'd66;
        b_valid = 1; b_dest = 4'd7; b_data = 32'd77;
        step();
        a_valid = 0; b_valid = 0;
        step();
        check("mrst_en_pre",  32'(enable), 32'h0080);
        check("mrst_idle_pre", 32'(idle),  32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_enable",  32'(enable),  32'h0);
        check("mrst_pending", 32'(pending), 32'h0);
        check("mrst_idle",    32'(idle),    32'h1);
        check("mrst_a_ready", 32'(a_ready), 32'h1);
        check("mrst_b_ready", 32'(b_ready), 32'h1);
        writes = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (enable != 16'h0) writes++;
        end
        check("mrst_writes", 32'(writes), 32'h0);
        check("mrst_r6",     bank[6],     32'hA006);

        // ---------------- randomised traffic ----------------
        for (int i = 0; i < 16; i++) exp_bank[i] = bank[i];
        viol = 0; n_acc = 0; n_pulse = 0;
        a_valid = 0; b_valid = 0;
        for (int c = 0; c < 10000; c++) begin
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            if (acc_a) begin exp_bank[a_dest] = a_data; n_acc++; end
            if (acc_b) begin exp_bank[b_dest] = b_data; n_acc++; end
            step();
            if ($countones(enable) > 1) viol++;
            if (enable != 16'h0) n_pulse++;
            if (!a_valid || acc_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_dest  = {3'($urandom_range(0, 7)), 1'b0};
                a_data  = $urandom;
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_dest  = {3'($urandom_range(0, 7)), 1'b1};
                b_data  = $urandom;
            end
        end
        a_valid = 0; b_valid = 0;
        for (int c = 0; c < 20 && !idle; c++) begin
            step();
            if ($countones(enable) > 1) viol++;
            if (enable != 16'h0) n_pulse++;
        end
        step();
        check("rand_idle",     32'(idle),    32'h1);
        check("rand_onehot",   32'(viol),    32'h0);
        check("rand_pulses",   32'(n_pulse), 32'(n_acc));
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rand_r%0d", i), bank[i], exp_bank[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_write_sched.md
Name: reg_write_sched

Overview:
- Write-port scheduler for the 16-entry register bank.
- Accepts writeback requests from two requesters, ALU result (port A) and LDR load data (port B), each through a valid/ready handshake with a one-entry holding buffer per port.
- Serialises them onto the bank's single write port by driving its one-hot enable and ldr_data inputs.
- Publishes a pending-write bitmap for hazard/stall logic upstream.

Parameters:
DATA_W, 32, width of write data, equal to the bank's ldr_data width
ADDR_W, 4, destination register index width; bank has 2**ADDR_W registers, enable is 2**ADDR_W bits

Ports:
clk  input  1  rising-edge clock, shared with the register bank
rst  input  1  synchronous active-high reset
a_valid  input  1  ALU writeback request valid
a_ready  output  1  ALU buffer can accept this cycle
a_dest  input  ADDR_W  ALU destination register index
a_data  input  DATA_W  ALU write data
b_valid  input  1  LDR writeback request valid
b_ready  output  1  LDR buffer can accept this cycle
b_dest  input  ADDR_W  LDR destination register index
b_data  input  DATA_W  LDR write data
enable  output  2**ADDR_W  one-hot write enable to register bank, registered
ldr_data  output  DATA_W  write data to register bank, registered
pending  output  2**ADDR_W  bit i set while any write to register i is buffered or on the output stage
idle  output  1  high when both buffers and output stage are empty

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous active-high on rst; it is sampled only at a rising edge of clk.
- Reset values: enable=0, ldr_data=0, both buffers EMPTY, age bit=0, round-robin pointer=A. Consequently a_ready=1, b_ready=1, pending=0 and idle=1 from the first cycle after reset.
- Reset mid-operation: buffered requests are discarded and never written. An enable pulse already registered is cleared at the reset edge.
- Per-port buffer FSM has two states, EMPTY and FULL.
  - EMPTY -> FULL on valid&ready; dest and data are captured.
  - FULL -> EMPTY when granted, unless a new valid arrives in the same cycle, in which case it stays FULL with the new contents.
- x_ready = (buffer EMPTY) | (buffer granted this cycle). Ready has a combinational path only from the grant, never from x_valid.
- Arbitration is evaluated every cycle over FULL buffers only.
  - One FULL: grant it.
  - Both FULL: grant the older one, tracked by an age bit set when the second buffer fills.
  - Both filled at the same edge: grant by round-robin pointer, then toggle the pointer.
  - Write order to any given register therefore follows acceptance order.
- Output stage is registered at the grant edge: enable <= one-hot(granted dest), ldr_data <= granted data.
  - If nothing is granted, enable <= 0 and ldr_data holds its value.
  - enable is never multi-hot. It is high for exactly one cycle per grant.
- Latency:
  - Accept at edge E0.
  - Grant evaluated in the cycle after E0; enable is asserted from edge E1.
  - The bank captures the data at edge E2.
  - Minimum accept-to-bank-update is 2 cycles.
- Throughput: one write per cycle sustained. Each port achieves back-to-back acceptance only while it wins arbitration.
- pending = decode(A dest if FULL) | decode(B dest if FULL) | enable. It is combinational from state, with no glitch dependence on inputs.
- idle = both buffers EMPTY & enable==0.
- Same dest in both buffers:
  - Two sequential enable pulses are issued, older first.
  - The bank ends holding the younger data.
  - pending[dest] stays set until the second pulse has been issued and cleared.
- Valid held high with ready low: the request is not accepted and the upstream holds dest/data. No data loss, no duplication.

Test Plan:
- Reset then single write: a_valid=1, a_dest=3, a_data=32'hDEADBEEF for one cycle -> enable=16'h0008 and ldr_data=32'hDEADBEEF for exactly one cycle, 1 cycle after accept; r3=32'hDEADBEEF next edge; pending[3] high from the accept edge until enable drops.
- Simultaneous first fill: A dest 1 data 11, B dest 2 data 22 at the same edge, pointer=A -> enable 16'h0002 then 16'h0004 on consecutive cycles. Repeat -> B is granted first.
- Ordering on a shared dest: B accepts dest 5 data 7, the next cycle A accepts dest 5 data 9 -> enable 16'h0020 with 7, then 16'h0020 with 9; r5 ends at 9; pending[5] clears only after the second pulse.
- Backpressure: both ports stream 8 requests each with valid held high -> 16 enable pulses on 16 consecutive cycles; each port's order is preserved; no ready=1 cycle with a dropped request; idle=1 at the end.
- Reset mid-operation: both buffers FULL and enable active, assert rst for one cycle -> the next cycle shows enable=0, pending=0, idle=1, ready=1, and no further bank writes.
- Never multi-hot: randomised 10k-cycle traffic with a scoreboard model of the bank -> popcount(enable)<=1 every cycle and final register contents match the model.
